// File: rtl/score_tracker.sv
// score_tracker: BCD score and session high-score bookkeeping for the
// egg-catcher game. Follows the game FSM's run level, adds survival points
// and catch bonuses in BCD with saturation at 9999, latches the high score
// when a game ends and drives the four active-low score displays.
module score_tracker #(
  parameter int unsigned TICKS_PER_POINT = 50_000_000,
  parameter int unsigned BONUS           = 5,
  parameter int unsigned BLINK_TICKS     = 25_000_000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        run,
  input  logic        catch_pulse,
  input  logic        show_high,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd,
  output logic        new_high,
  output logic [1:0]  state_dbg,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  localparam int unsigned PRESC_W = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_POINT - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [4:0] BONUS_INC = 5'(BONUS);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_OVER = 2'b10
  } state_t;

  state_t             state_reg, state_next;
  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
  logic               blink_on_reg, blink_on_next;
  logic [15:0]        score_reg, score_next;
  logic [15:0]        high_reg, high_next;
  logic               new_high_reg, new_high_next;

  logic        point_tick;
  logic        add_en;
  logic        enter_run;
  logic        leave_run;
  logic [4:0]  inc;
  logic [15:0] sum_bcd;
  logic        sum_overflow;
  logic        blank_all;
  logic [15:0] disp_bcd;
  logic [6:0]  hex_seg [4];

  // Both IDLE and OVER start a new game on run; a game ends when run drops.
  assign enter_run  = (state_reg != S_RUN) && run;
  assign leave_run  = (state_reg == S_RUN) && !run;
  // Points are only earned while the game is still running this cycle, so
  // nothing is added on the edge that ends the game.
  assign add_en     = (state_reg == S_RUN) && run;
  assign point_tick = (state_reg == S_RUN) && (presc_reg == PRESC_LAST);
  assign inc        = {4'b0000, point_tick} + (catch_pulse ? BONUS_INC : 5'd0);

  // Game state: next-state selection from the run level.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (run)  state_next = S_RUN;
      S_RUN:   if (!run) state_next = S_OVER;
      S_OVER:  if (run)  state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  // Per-digit BCD add of the increment; a carry out of the thousands digit saturates.
  always_comb begin
    logic [4:0] dsum;
    logic       carry;
    sum_bcd = '0;
    carry   = 1'b0;
    dsum    = '0;
    for (int i = 0; i < 4; i++) begin
      dsum  = {1'b0, score_reg[4*i +: 4]} + ((i == 0) ? inc : {4'b0000, carry});
      carry = (dsum > 5'd9);
      sum_bcd[4*i +: 4] = carry ? 4'(dsum - 5'd10) : dsum[3:0];
    end
    sum_overflow = carry;
  end

  // Prescaler, blink phase, score and high-score next values.
  always_comb begin
    presc_next     = '0;
    blink_cnt_next = '0;
    blink_on_next  = 1'b1;
    score_next     = score_reg;
    high_next      = high_reg;
    new_high_next  = new_high_reg;

    // Prescaler only runs inside a live game; everywhere else it sits at zero.
    if (add_en && !point_tick) begin
      presc_next = presc_reg + PRESC_W'(1);
    end

    // Blink phase free-runs in OVER and restarts "on" whenever OVER is entered.
    if ((state_reg == S_OVER) && !run) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_next = '0;
        blink_on_next  = !blink_on_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + BLINK_W'(1);
        blink_on_next  = blink_on_reg;
      end
    end

    if (enter_run || (state_reg == S_IDLE)) begin
      score_next = '0;
    end else if (add_en) begin
      score_next = sum_overflow ? 16'h9999 : sum_bcd;
    end

    if (enter_run) begin
      new_high_next = 1'b0;
    end

    // Valid BCD orders numerically the same as its packed binary value.
    if (leave_run && (score_reg > high_reg)) begin
      high_next     = score_reg;
      new_high_next = 1'b1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      presc_reg     <= '0;
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      presc_reg     <= presc_next;
      blink_cnt_reg <= blink_cnt_next;
      blink_on_reg  <= blink_on_next;
    end
  end

  // Score registers; reset is the only way to clear the high score.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      score_reg    <= '0;
      high_reg     <= '0;
      new_high_reg <= 1'b0;
    end else begin
      score_reg    <= score_next;
      high_reg     <= high_next;
      new_high_reg <= new_high_next;
    end
  end

  assign score_bcd = score_reg;
  assign high_bcd  = high_reg;
  assign new_high  = new_high_reg;
  assign state_dbg = state_reg;

  // Only a fresh high score blinks, and only after the game is over.
  assign blank_all = (state_reg == S_OVER) && new_high_reg && !blink_on_reg;
  assign disp_bcd  = show_high ? high_reg : score_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      // Active-low seven-segment decode of one digit; non-BCD codes blank.
      always_comb begin
        hex_seg[gi] = 7'b1111111;
        if (!blank_all) begin
          case (disp_bcd[4*gi +: 4])
            4'd0:    hex_seg[gi] = 7'b1000000;
            4'd1:    hex_seg[gi] = 7'b1111001;
            4'd2:    hex_seg[gi] = 7'b0100100;
            4'd3:    hex_seg[gi] = 7'b0110000;
            4'd4:    hex_seg[gi] = 7'b0011001;
            4'd5:    hex_seg[gi] = 7'b0010010;
            4'd6:    hex_seg[gi] = 7'b0000010;
            4'd7:    hex_seg[gi] = 7'b1111000;
            4'd8:    hex_seg[gi] = 7'b0000000;
            4'd9:    hex_seg[gi] = 7'b0010000;
            default: hex_seg[gi] = 7'b1111111;
          endcase
        end
      end
    end
  endgenerate

  assign hex0 = hex_seg[0];
  assign hex1 = hex_seg[1];
  assign hex2 = hex_seg[2];
  assign hex3 = hex_seg[3];

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker with short prescale/blink periods.
// A tiny integer score model tracks point ticks and catches for long runs.
module tb_score_tracker;
  localparam int TPP = 4;
  localparam int BON = 5;
  localparam int BLK = 3;

  localparam logic [6:0] SEG0  = 7'b1000000;
  localparam logic [6:0] SEG1  = 7'b1111001;
  localparam logic [6:0] SEG2  = 7'b0100100;
  localparam logic [6:0] SEG3  = 7'b0110000;
  localparam logic [6:0] SEG5  = 7'b0010010;
  localparam logic [6:0] SEG9  = 7'b0010000;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        run = 1'b0;
  logic        catch_pulse = 1'b0;
  logic        show_high = 1'b0;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic        new_high;
  logic [1:0]  state_dbg;
  logic [6:0]  hex0, hex1, hex2, hex3;

  int checks_cnt = 0;
  int fail_cnt   = 0;
  int model_score = 0;
  int k_cnt = 0;

  score_tracker #(
    .TICKS_PER_POINT(TPP),
    .BONUS(BON),
    .BLINK_TICKS(BLK)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .run(run),
    .catch_pulse(catch_pulse),
    .show_high(show_high),
    .score_bcd(score_bcd),
    .high_bcd(high_bcd),
    .new_high(new_high),
    .state_dbg(state_dbg),
    .hex0(hex0),
    .hex1(hex1),
    .hex2(hex2),
    .hex3(hex3)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // One RUN cycle: a point tick lands on every TPP-th edge after game start.
  task automatic step(input logic c);
    catch_pulse = c;
    @(posedge clock);
    k_cnt++;
    model_score += ((k_cnt % TPP) == 0 ? 1 : 0) + (c ? BON : 0);
    if (model_score > 9999) model_score = 9999;
    #1;
    catch_pulse = 1'b0;
  endtask

  task automatic start_game;
    run = 1'b1;
    @(posedge clock);
    #1;
    k_cnt = 0;
    model_score = 0;
  endtask

  task automatic end_game;
    run = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Catch every cycle until close, then let ticks land exactly on target.
  task automatic run_to(input int target);
    while (target - model_score > 10) step(1'b1);
    while (model_score < target) step(1'b0);
    check($sformatf("run_to_%0d", target), score_bcd, to_bcd(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    wait_cycles(2);
    check("rst_score", score_bcd, 16'h0000);
    check("rst_high", high_bcd, 16'h0000);
    check("rst_new_high", {15'd0, new_high}, 16'd0);
    check("rst_state", {14'd0, state_dbg}, 16'd0);
    check("rst_hex0", {9'd0, hex0}, {9'd0, SEG0});
    check("rst_hex3", {9'd0, hex3}, {9'd0, SEG0});
    resetn = 1'b1;
    wait_cycles(1);
    check("idle_state", {14'd0, state_dbg}, 16'd0);

    // Survival points only: 40 cycles -> 10 points
    start_game;
    check("run_state", {14'd0, state_dbg}, 16'd1);
    check("run_entry_score", score_bcd, 16'h0000);
    repeat (40) step(1'b0);
    check("score_40cyc", score_bcd, 16'h0010);
    check("hex1_40cyc", {9'd0, hex1}, {9'd0, SEG1});
    check("hex0_40cyc", {9'd0, hex0}, {9'd0, SEG0});

    // run 1->0->1 on consecutive cycles
    end_game;
    check("over_state", {14'd0, state_dbg}, 16'd2);
    check("high_after_g0", high_bcd, 16'h0010);
    check("new_high_g0", {15'd0, new_high}, 16'd1);
    start_game;
    check("restart_state", {14'd0, state_dbg}, 16'd1);
    check("restart_score", score_bcd, 16'h0000);
    check("restart_new_high", {15'd0, new_high}, 16'd0);
    check("restart_high_kept", high_bcd, 16'h0010);

    // Catch coinciding with a tick from 8 -> 14
    run_to(8);
    while (((k_cnt + 1) % TPP) != 0) step(1'b0);
    step(1'b1);
    check("tick_plus_catch", score_bcd, 16'h0014);

    // High score 305 and show_high display, blink, catch ignored in OVER
    run_to(305);
    end_game;
    check("high_305", high_bcd, 16'h0305);
    show_high = 1'b1;
    #1;
    check("sh_hex0", {9'd0, hex0}, {9'd0, SEG5});
    check("sh_hex1", {9'd0, hex1}, {9'd0, SEG0});
    check("sh_hex2", {9'd0, hex2}, {9'd0, SEG3});
    check("sh_hex3", {9'd0, hex3}, {9'd0, SEG0});
    catch_pulse = 1'b1;
    @(posedge clock);
    #1;
    catch_pulse = 1'b0;
    check("over_catch_ignored", score_bcd, 16'h0305);
    wait_cycles(1);
    check("sh_blink_on", {9'd0, hex0}, {9'd0, SEG5});
    wait_cycles(1);
    check("sh_blink_off", {9'd0, hex2}, {9'd0, BLANK});
    show_high = 1'b0;

    // Reset clears the high score; then mid-RUN reset
    resetn = 1'b0;
    wait_cycles(1);
    resetn = 1'b1;
    wait_cycles(1);
    check("rst_clears_high", high_bcd, 16'h0000);
    start_game;
    run_to(50);
    end_game;
    check("high_50", high_bcd, 16'h0050);
    start_game;
    run_to(7);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_score", score_bcd, 16'h0000);
    check("midrst_high", high_bcd, 16'h0000);
    check("midrst_state", {14'd0, state_dbg}, 16'd0);
    run = 1'b0;
    resetn = 1'b1;
    wait_cycles(1);

    // Game 1 ends at 12: new high, blink every 3 cycles
    start_game;
    run_to(12);
    end_game;
    check("g1_high", high_bcd, 16'h0012);
    check("g1_new_high", {15'd0, new_high}, 16'd1);
    check("g1_on_hex0", {9'd0, hex0}, {9'd0, SEG2});
    check("g1_on_hex1", {9'd0, hex1}, {9'd0, SEG1});
    wait_cycles(2);
    check("g1_on2_hex0", {9'd0, hex0}, {9'd0, SEG2});
    wait_cycles(1);
    check("g1_off_hex0", {9'd0, hex0}, {9'd0, BLANK});
    check("g1_off_hex3", {9'd0, hex3}, {9'd0, BLANK});
    wait_cycles(2);
    check("g1_off2_hex1", {9'd0, hex1}, {9'd0, BLANK});
    wait_cycles(1);
    check("g1_on3_hex0", {9'd0, hex0}, {9'd0, SEG2});

    // Game 2 ends at 12: equal score, no new high, no blink
    start_game;
    check("g2_entry_new_high", {15'd0, new_high}, 16'd0);
    run_to(12);
    end_game;
    check("g2_high", high_bcd, 16'h0012);
    check("g2_new_high", {15'd0, new_high}, 16'd0);
    wait_cycles(3);
    check("g2_noblink_hex0", {9'd0, hex0}, {9'd0, SEG2});
    check("g2_noblink_hex1", {9'd0, hex1}, {9'd0, SEG1});

    // Saturation at 9999
    start_game;
    run_to(9997);
    step(1'b1);
    check("sat_catch", score_bcd, 16'h9999);
    repeat (8) step(1'b0);
    check("sat_hold", score_bcd, 16'h9999);
    end_game;
    check("sat_high", high_bcd, 16'h9999);
    check("sat_new_high", {15'd0, new_high}, 16'd1);
    check("sat_hex3", {9'd0, hex3}, {9'd0, SEG9});

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end
endmodule
